// File: rtl/axil_pkg.sv
// Shared types and address decode for the AXI-lite register bank.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_t;

    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic                  err;
        logic [ADDR_WIDTH-1:0] idx;
    } dec_t;

    // Word index relative to the bank base; err flags below-base or past-the-end.
    function automatic dec_t addr_to_idx(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ADDR_WIDTH-1:0] base,
        input int unsigned           lsb,
        input int unsigned           num_regs
    );
        dec_t                  d;
        logic [ADDR_WIDTH-1:0] off;
        off   = addr - base;
        d.idx = off >> lsb;
        d.err = (addr < base) || (d.idx >= num_regs);
        return d;
    endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Joins independent AW and W channels into a single commit strobe and runs the B channel.
module axil_wr_join
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [31:0]             awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    o_commit,
    output logic [31:0]             o_cm_addr,
    output logic [DATA_WIDTH-1:0]   o_cm_data,
    output logic [DATA_WIDTH/8-1:0] o_cm_strb,
    input  resp_t                   i_cm_resp
);

    wr_state_t               r_state;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [31:0]             r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;

    logic w_aw_hs;
    logic w_w_hs;

    assign awready = !areset && !r_aw_held && !r_bvalid;
    assign wready  = !areset && !r_w_held && !r_bvalid;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;

    // A channel counts as present if buffered earlier or handshaking right now.
    assign o_commit  = (r_state == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign o_cm_addr = r_aw_held ? r_awaddr : awaddr;
    assign o_cm_data = r_w_held ? r_wdata : wdata;
    assign o_cm_strb = r_w_held ? r_wstrb : wstrb;

    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= WR_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            case (r_state)
                WR_IDLE: begin
                    if (o_commit) begin
                        r_state   <= WR_RESP;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= i_cm_resp;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= wdata;
                            r_wstrb  <= wstrb;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        r_state  <= WR_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI-lite register bank: RW registers with byte strobes, RO status passthrough, write pulses.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_REGS   = 16,
    parameter logic [31:0]          BASE_ADDR  = 32'h0,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [31:0]                    awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [31:0]                    araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);

    logic                                 w_commit;
    logic [31:0]                          w_cm_addr;
    logic [DATA_WIDTH-1:0]                w_cm_data;
    logic [STRB_W-1:0]                    w_cm_strb;
    resp_t                                w_cm_resp;
    dec_t                                 w_cm_dec;
    dec_t                                 w_ar_dec;
    logic [NUM_REGS-1:0]                  w_wr_hit;
    logic [NUM_REGS-1:0]                  w_rd_hit;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  w_rd_vec;
    logic [DATA_WIDTH-1:0]                w_rd_data;

    rd_state_t             r_rd_state;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    resp_t                 r_rresp;

    axil_wr_join #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wr_join (
        .aclk      (aclk),
        .areset    (areset),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .o_commit  (w_commit),
        .o_cm_addr (w_cm_addr),
        .o_cm_data (w_cm_data),
        .o_cm_strb (w_cm_strb),
        .i_cm_resp (w_cm_resp)
    );

    assign w_cm_dec  = addr_to_idx(w_cm_addr, BASE_ADDR, LSB, NUM_REGS);
    assign w_ar_dec  = addr_to_idx(araddr, BASE_ADDR, LSB, NUM_REGS);
    assign w_cm_resp = (w_cm_dec.err || |(w_wr_hit & RO_MASK)) ? SLVERR : OKAY;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_val;
            logic                  r_pulse;
            logic                  w_wr_en;

            assign w_wr_hit[gi] = !w_cm_dec.err && (w_cm_dec.idx == 32'(gi));
            assign w_rd_hit[gi] = !w_ar_dec.err && (w_ar_dec.idx == 32'(gi));
            assign w_wr_en      = w_commit && w_wr_hit[gi] && !RO_MASK[gi];

            // Pulse follows the commit even with an all-zero strobe.
            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_val   <= '0;
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= w_wr_en;
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_wr_en && w_cm_strb[k]) begin
                            r_val[k*8 +: 8] <= w_cm_data[k*8 +: 8];
                        end
                    end
                end
            end

            assign w_rd_vec[gi]                        = RO_MASK[gi] ? status_i[gi*DATA_WIDTH +: DATA_WIDTH] : r_val;
            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[gi] ? '0 : r_val;
            assign wr_pulse_o[gi]                      = r_pulse;
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_hit[i]) begin
                w_rd_data = w_rd_vec[i];
            end
        end
    end

    assign arready = !areset && !r_rvalid;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    // Read samples the pre-commit register value when it coincides with a write commit.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (arvalid) begin
                        r_rd_state <= RD_VALID;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_ar_dec.err ? SLVERR : OKAY;
                    end
                end
                RD_VALID: begin
                    if (rready) begin
                        r_rd_state <= RD_IDLE;
                        r_rvalid   <= 1'b0;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

Parametrised AXI-lite slave register bank, replacing hand-rolled per-accelerator control/status registers. Exposes `NUM_REGS` data-width registers to a host master over AXI-lite, adding byte strobes, 2-bit responses, read-only status registers fed from hardware, and per-register write pulses. AW and W channels are accepted independently and in either order.

## Interface
- `DATA_WIDTH`, 32: register and bus width; 32 or 64 only.
- `NUM_REGS`, 16: register count, 1–256.
- `BASE_ADDR`, 32'h0: byte address of register 0; aligned to `DATA_WIDTH/8`.
- `RO_MASK`, '0: `NUM_REGS` bits; bit i=1 makes register i read-only.
- `aclk`  in  1  clock.
- `areset`  in  1  synchronous, active-high reset.
- `awaddr`  in  32, `awvalid` in 1, `awready` out 1: write address.
- `wdata`  in  DATA_WIDTH, `wstrb` in DATA_WIDTH/8, `wvalid` in 1, `wready` out 1: write data.
- `bresp`  out  2, `bvalid` out 1, `bready` in 1: write response.
- `araddr`  in  32, `arvalid` in 1, `arready` out 1: read address.
- `rdata`  out  DATA_WIDTH, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data.
- `regs_o`  out  NUM_REGS×DATA_WIDTH: current value of each RW register (RO entries read 0).
- `status_i`  in  NUM_REGS×DATA_WIDTH: value returned for RO registers; ignored for RW.
- `wr_pulse_o`  out  NUM_REGS: one-cycle strobe per successful write.

## Operation
- Decode: `idx = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8)`. Low byte-offset bits are ignored. Decode error if `addr < BASE_ADDR` or `idx ≥ NUM_REGS`.
- Write channel, two flags `aw_held` and `w_held`, plus state IDLE/RESP:
  - `awready = !aw_held && !bvalid`; `wready = !w_held && !bvalid` (both 0 during reset).
  - A handshake captures the channel into its buffer.
  - The write commits on the edge where both channels are held or are handshaking that cycle. At that edge, state → RESP, `bvalid`=1 and flags clear.
  - RESP → IDLE on `bvalid && bready`.
- Commit rules:
  - Decode error or RO target: `bresp`=SLVERR (2'b10), no register change, no pulse.
  - Otherwise each byte lane k with `wstrb[k]`=1 is updated, `bresp`=OKAY, and `wr_pulse_o[idx]`=1 for exactly the commit+1 cycle. A pulse fires even when `wstrb`=0.
- Read channel, IDLE/RVALID:
  - `arready = !rvalid`.
  - On handshake, `rdata`/`rresp` are registered, giving `rvalid` the next cycle. The value is `regs` for RW, `status_i` sampled at the handshake edge for RO, and 0 with SLVERR on decode error.
  - `rdata`/`rresp` are held stable until `rvalid && rready`.
- Read and write are fully independent. A read accepted on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset: all registers 0, `bvalid`=`rvalid`=0, `bresp`=`rresp`=0, `rdata`=0, `wr_pulse_o`=0, both flags clear. Readies are 0 while `areset` is high and 1 on the first cycle after.
- Reset mid-transaction discards any held AW/W and any pending B/R response. A master must reissue.
- Write latency from last of AW/W handshake to `bvalid`: 1 cycle. `regs_o` changes on the same edge `bvalid` rises.
- Back-to-back writes: minimum 2 cycles per write (readies low during RESP).
- Read latency from `arvalid && arready` to `rvalid`: 1 cycle. Back-to-back reads: 2 cycles each.
- `bvalid`/`rvalid` are never deasserted without the matching ready.

## Structure
- Package `axil_pkg`:
  - `resp_t` enum: OKAY=2'b00, SLVERR=2'b10.
  - `addr_to_idx` function for decode and range check.
  - `wr_state_t` and `rd_state_t` enums.
- One sub-module, `axil_wr_join`, owns AW/W buffering, the commit strobe and the B-channel FSM.
- The top level holds the register array, strobe merge, RO muxing and read FSM.

## Test plan
- **Write, AW and W same cycle:** addr 0x8, data 0xDEADBEEF, strb 4'hF → `bvalid` the next cycle with OKAY, `regs_o[2]`=0xDEADBEEF, `wr_pulse_o[2]` high 1 cycle.
- **W 3 cycles before AW:** W data 0x1234, strb 4'b0011 to reg 1 (previous value 0xFFFFFFFF), AW addr 0x4 arrives 3 cycles later → `wready` low after capture; `bvalid` 1 cycle after the AW handshake; reg 1 = 0xFFFF1234.
- **Errors:**
  - Write to addr 0x40 with `NUM_REGS`=16 → SLVERR, no pulse, no change.
  - Write to an RO register → SLVERR.
  - Read 0x40 → `rdata`=0, SLVERR.
- **RO read:** `status_i[3]`=0xA5A5 → read 0xC returns 0xA5A5 with OKAY. With `rready` low for 4 cycles, `rdata` stays stable.
- **Same-register collision:** reg 0 = 5; write 7 to reg 0 and read reg 0 on the same edge → read returns 5, and a subsequent read returns 7.
- **Reset mid-write:** assert `areset` with AW held and W pending → after release, `bvalid`=0, register unchanged, readies 1.
